// File: rtl/key_debounce_mc.sv
// key_debounce_mc: per-channel key debouncer with press/release/long/repeat pulses.
module key_debounce_mc #(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYC    = 1_000_000,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REP_CYC    = 10_000_000,
  parameter bit ACTIVE_LOW = 1,
  parameter bit REPEAT_EN  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);
  localparam int DW   = $clog2(DEB_CYC);
  localparam int HMAX = LONG_CYC > REP_CYC ? LONG_CYC : REP_CYC;
  localparam int HW   = $clog2(HMAX);
  localparam logic [N_KEYS-1:0] IDLE = ACTIVE_LOW ? '1 : '0;
  typedef enum logic [1:0] {REL, CHK_P, HELD, CHK_R} st_t;
  logic [N_KEYS-1:0] s1, s2, r;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  assign r = ACTIVE_LOW ? ~s2 : s2;
  genvar g;
  for (g = 0; g < N_KEYS; g++) begin : ch
    st_t st;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic lng, ks, pp, rp, lp, qp;
    logic dterm, lterm, rterm, hold;
    assign dterm = dcnt == DW'(DEB_CYC - 1);
    assign lterm = !lng && hcnt == HW'(LONG_CYC - 1);
    assign rterm = lng && REPEAT_EN && hcnt == HW'(REP_CYC - 1);
    // a pressed sample in CHK_R counts as hold time, so a glitch costs only its own length
    assign hold  = r[g] && (st == HELD || st == CHK_R);
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        st   <= REL;
        dcnt <= '0;
        hcnt <= '0;
        lng  <= 1'b0;
        ks   <= 1'b0;
        pp   <= 1'b0;
        rp   <= 1'b0;
        lp   <= 1'b0;
        qp   <= 1'b0;
      end else begin
        pp <= 1'b0;
        rp <= 1'b0;
        lp <= 1'b0;
        qp <= 1'b0;
        if (hold) begin
          if (lterm) begin
            lp   <= 1'b1;
            lng  <= 1'b1;
            hcnt <= '0;
          end else if (rterm) begin
            qp   <= 1'b1;
            hcnt <= '0;
          end else if (!lng || REPEAT_EN) hcnt <= hcnt + HW'(1);
        end
        case (st)
          REL: if (r[g]) begin
            st   <= CHK_P;
            dcnt <= '0;
          end
          CHK_P: if (!r[g]) st <= REL;
          else if (dterm) begin
            st   <= HELD;
            dcnt <= '0;
            ks   <= 1'b1;
            pp   <= 1'b1;
            hcnt <= '0;
            lng  <= 1'b0;
          end else dcnt <= dcnt + DW'(1);
          HELD: if (!r[g]) begin
            st   <= CHK_R;
            dcnt <= '0;
          end
          default: if (r[g]) st <= HELD;
          else if (dterm) begin
            st   <= REL;
            dcnt <= '0;
            ks   <= 1'b0;
            rp   <= 1'b1;
            lng  <= 1'b0;
          end else dcnt <= dcnt + DW'(1);
        endcase
      end
    assign key_state[g]     = ks;
    assign press_pulse[g]   = pp;
    assign release_pulse[g] = rp;
    assign long_pulse[g]    = lp;
    assign repeat_pulse[g]  = qp;
  end
endmodule

// File: tb/tb_key_debounce_mc.sv
// tb_key_debounce_mc: directed checks of debounce latency, glitch rejection, long/repeat and reset.
module tb_key_debounce_mc;
  logic clk = 0, rstn = 0;
  logic [3:0] key_in = 4'hF;
  logic [3:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  int cyc = 0, total = 0, fails = 0;
  int n_press[4], n_rel[4], n_long[4], n_rep[4], t_press[4], t_rel[4], t_long[4];
  int rep_t[$];
  int t0, p, b_press, b_rel, b_long, b_rep;

  key_debounce_mc #(.N_KEYS(4), .DEB_CYC(8), .LONG_CYC(40), .REP_CYC(10),
                    .ACTIVE_LOW(1), .REPEAT_EN(1)) dut (
    .clk(clk), .rstn(rstn), .key_in(key_in), .key_state(key_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 4; i++) begin
    n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
    t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1;
  end

  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (press_pulse[i]) begin n_press[i]++; t_press[i] = cyc; end
      if (release_pulse[i]) begin n_rel[i]++; t_rel[i] = cyc; end
      if (long_pulse[i]) begin n_long[i]++; t_long[i] = cyc; end
      if (repeat_pulse[i]) begin
        n_rep[i]++;
        if (i == 2) rep_t.push_back(cyc);
      end
    end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    step(3);
    chk("reset_outputs", {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    rstn = 1;
    step(12);
    chk("idle_state", key_state, 0);
    chk("idle_press_cnt", n_press[0] + n_press[1] + n_press[2] + n_press[3], 0);

    t0 = cyc; key_in[0] = 0;
    step(20);
    chk("clean_press_time", t_press[0], t0 + 11);
    chk("clean_press_cnt", n_press[0], 1);
    chk("clean_key_state", key_state, 4'b0001);
    chk("clean_no_long", n_long[0], 0);
    t0 = cyc; key_in[0] = 1;
    step(12);
    chk("clean_release_time", t_rel[0], t0 + 11);
    chk("clean_release_state", key_state, 0);

    key_in[1] = 0; step(5);
    key_in[1] = 1; step(1);
    key_in[1] = 0; step(5);
    key_in[1] = 1; step(15);
    chk("bounce_no_press", n_press[1], 0);
    chk("bounce_state", key_state[1], 0);

    b_rep = rep_t.size();
    t0 = cyc; key_in[2] = 0;
    step(11);
    chk("long_press_time", t_press[2], t0 + 11);
    p = t_press[2];
    step(100);
    key_in[2] = 1;
    step(14);
    chk("long_time", t_long[2], p + 40);
    chk("long_cnt", n_long[2], 1);
    chk("repeat_cnt", rep_t.size() - b_rep, 6);
    for (int j = 0; j < 6 && b_rep + j < rep_t.size(); j++)
      chk($sformatf("repeat_time_%0d", j), rep_t[b_rep + j], p + 50 + 10 * j);
    chk("long_release_time", t_rel[2], p + 111);
    chk("long_release_cnt", n_rel[2], 1);

    t0 = cyc; key_in[2] = 0;
    step(11);
    p = t_press[2];
    chk("glitch_press_time", p, t0 + 11);
    step(20);
    key_in[2] = 1; step(3);
    key_in[2] = 0; step(22);
    chk("glitch_no_release", n_rel[2], 1);
    chk("glitch_long_time", t_long[2], p + 43);
    chk("glitch_long_cnt", n_long[2], 2);
    key_in[2] = 1;
    step(12);
    chk("glitch_release_cnt", n_rel[2], 2);

    key_in = 4'b0110;
    step(10);
    chk("simul_before", press_pulse, 0);
    step(1);
    chk("simul_press", press_pulse, 4'b1001);
    step(1);
    chk("simul_state", key_state, 4'b1001);
    key_in = 4'hF;
    step(12);
    chk("simul_release_state", key_state, 0);

    key_in[2] = 0;
    step(15);
    chk("rst_held_state", key_state, 4'b0100);
    b_rel = n_rel[2]; b_press = n_press[2]; b_long = n_long[2];
    rstn = 0;
    #1;
    chk("rst_outputs_now", {key_state, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    step(3);
    rstn = 1;
    step(10);
    chk("rst_before_press", press_pulse, 0);
    step(1);
    chk("rst_repress", press_pulse, 4'b0100);
    chk("rst_no_release", n_rel[2], b_rel);
    chk("rst_press_cnt", n_press[2], b_press + 1);
    chk("rst_long_cnt", n_long[2], b_long);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
